// File: rtl/pipereg_em_param.sv
// Execute-to-Memory pipeline register, DEPTH cascaded stages, with stall/flush,
// in-flight result forwarding lookup and a saturating bubble counter.
module pipereg_em_param #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallE,
  input  logic               flushE,
  input  logic               validE,
  input  logic               regwriteE,
  input  logic               memtoregE,
  input  logic               memwriteE,
  input  logic [XLEN-1:0]    aluoutE,
  input  logic [XLEN-1:0]    writedataE,
  input  logic [RADDR_W-1:0] writeregE,
  output logic               validM,
  output logic               regwriteM,
  output logic               memtoregM,
  output logic               memwriteM,
  output logic [XLEN-1:0]    aluoutM,
  output logic [XLEN-1:0]    writedataM,
  output logic [RADDR_W-1:0] writeregM,
  input  logic [RADDR_W-1:0] fwdqry,
  output logic               fwdhit,
  output logic [XLEN-1:0]    fwddata,
  output logic [CNT_W-1:0]   bubblecnt
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $fatal(1, "pipereg_em_param: DEPTH must be in 1..4");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Index 0 is stage 1 (youngest), index DEPTH-1 drives the M outputs.
  logic               vld_q [DEPTH];
  logic               rw_q  [DEPTH];
  logic               mr_q  [DEPTH];
  logic               mw_q  [DEPTH];
  logic [XLEN-1:0]    alu_q [DEPTH];
  logic [XLEN-1:0]    wd_q  [DEPTH];
  logic [RADDR_W-1:0] wr_q  [DEPTH];
  logic [CNT_W-1:0]   cnt_q;

  logic               vld_d, rw_d, mr_d, mw_d;
  logic [XLEN-1:0]    alu_d, wd_d;
  logic [RADDR_W-1:0] wr_d;
  logic [CNT_W-1:0]   cnt_d;

  // Stage-1 next state: flush beats stall; control is masked by validE.
  always_comb begin
    vld_d = vld_q[0];
    rw_d  = rw_q[0];
    mr_d  = mr_q[0];
    mw_d  = mw_q[0];
    alu_d = alu_q[0];
    wd_d  = wd_q[0];
    wr_d  = wr_q[0];
    if (flushE) begin
      vld_d = 1'b0;
      rw_d  = 1'b0;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      alu_d = '0;
      wd_d  = '0;
      wr_d  = '0;
    end else if (!stallE) begin
      vld_d = validE;
      rw_d  = regwriteE & validE;
      mr_d  = memtoregE & validE;
      mw_d  = memwriteE & validE;
      alu_d = aluoutE;
      wd_d  = writedataE;
      wr_d  = writeregE;
    end
    cnt_d = flushE ? sat_inc(cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        vld_q[k] <= 1'b0;
        rw_q[k]  <= 1'b0;
        mr_q[k]  <= 1'b0;
        mw_q[k]  <= 1'b0;
        alu_q[k] <= '0;
        wd_q[k]  <= '0;
        wr_q[k]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      vld_q[0] <= vld_d;
      rw_q[0]  <= rw_d;
      mr_q[0]  <= mr_d;
      mw_q[0]  <= mw_d;
      alu_q[0] <= alu_d;
      wd_q[0]  <= wd_d;
      wr_q[0]  <= wr_d;
      for (int k = 1; k < DEPTH; k++) begin
        if (!stallE) begin
          vld_q[k] <= vld_q[k-1];
          rw_q[k]  <= rw_q[k-1];
          mr_q[k]  <= mr_q[k-1];
          mw_q[k]  <= mw_q[k-1];
          alu_q[k] <= alu_q[k-1];
          wd_q[k]  <= wd_q[k-1];
          wr_q[k]  <= wr_q[k-1];
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign validM     = vld_q[DEPTH-1];
  assign regwriteM  = rw_q[DEPTH-1];
  assign memtoregM  = mr_q[DEPTH-1];
  assign memwriteM  = mw_q[DEPTH-1];
  assign aluoutM    = alu_q[DEPTH-1];
  assign writedataM = wd_q[DEPTH-1];
  assign writeregM  = wr_q[DEPTH-1];
  assign bubblecnt  = cnt_q;

  // Scan oldest to youngest so the youngest matching stage wins; loads are skipped.
  always_comb begin
    fwdhit  = 1'b0;
    fwddata = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (vld_q[k] && rw_q[k] && !mr_q[k] && (wr_q[k] == fwdqry) && (fwdqry != '0)) begin
        fwdhit  = 1'b1;
        fwddata = alu_q[k];
      end
    end
  end

endmodule

// File: tb/tb_pipereg_em_param.sv
// Bench for pipereg_em_param: DEPTH=1, DEPTH=2 (CNT_W=2) and DEPTH=3 instances
// share one stimulus stream and are checked against an in-bench item-list model.
module tb_pipereg_em_param;

  typedef struct packed {
    logic        v, rw, mr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  wr;
  } st_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallE = 1'b0, flushE = 1'b0, validE = 1'b0;
  logic        regwriteE = 1'b0, memtoregE = 1'b0, memwriteE = 1'b0;
  logic [31:0] aluoutE = '0, writedataE = '0;
  logic [4:0]  writeregE = '0, fwdqry = '0;

  logic        o_v [3], o_rw [3], o_mr [3], o_mw [3], o_hit [3];
  logic [31:0] o_alu [3], o_wd [3], o_fd [3];
  logic [4:0]  o_wr [3];
  logic [15:0] cnt1, cnt3;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  pipereg_em_param #(.XLEN(32), .RADDR_W(5), .DEPTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validE(validE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
    .aluoutE(aluoutE), .writedataE(writedataE), .writeregE(writeregE),
    .validM(o_v[0]), .regwriteM(o_rw[0]), .memtoregM(o_mr[0]), .memwriteM(o_mw[0]),
    .aluoutM(o_alu[0]), .writedataM(o_wd[0]), .writeregM(o_wr[0]),
    .fwdqry(fwdqry), .fwdhit(o_hit[0]), .fwddata(o_fd[0]), .bubblecnt(cnt1));

  pipereg_em_param #(.XLEN(32), .RADDR_W(5), .DEPTH(2), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validE(validE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
    .aluoutE(aluoutE), .writedataE(writedataE), .writeregE(writeregE),
    .validM(o_v[1]), .regwriteM(o_rw[1]), .memtoregM(o_mr[1]), .memwriteM(o_mw[1]),
    .aluoutM(o_alu[1]), .writedataM(o_wd[1]), .writeregM(o_wr[1]),
    .fwdqry(fwdqry), .fwdhit(o_hit[1]), .fwddata(o_fd[1]), .bubblecnt(cnt2));

  pipereg_em_param #(.XLEN(32), .RADDR_W(5), .DEPTH(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE), .validE(validE),
    .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
    .aluoutE(aluoutE), .writedataE(writedataE), .writeregE(writeregE),
    .validM(o_v[2]), .regwriteM(o_rw[2]), .memtoregM(o_mr[2]), .memwriteM(o_mw[2]),
    .aluoutM(o_alu[2]), .writedataM(o_wd[2]), .writeregM(o_wr[2]),
    .fwdqry(fwdqry), .fwdhit(o_hit[2]), .fwddata(o_fd[2]), .bubblecnt(cnt3));

  // Model: per instance, an ordered list of in-flight items (youngest first)
  // plus a bubble tally clipped to the counter's maximum.
  st_t mq [3][4];
  int  bc [3];
  int  dep  [3] = '{1, 2, 3};
  int  bmax [3] = '{65535, 3, 65535};

  always @(posedge clk or negedge rst_n) begin
    st_t nw;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        bc[i] = 0;
        for (int p = 0; p < 4; p++) mq[i][p] = '0;
      end
    end else begin
      nw = '0;
      if (!flushE) begin
        nw.v   = validE;
        nw.rw  = regwriteE & validE;
        nw.mr  = memtoregE & validE;
        nw.mw  = memwriteE & validE;
        nw.alu = aluoutE;
        nw.wd  = writedataE;
        nw.wr  = writeregE;
      end
      for (int i = 0; i < 3; i++) begin
        if (stallE) begin
          if (flushE) mq[i][0] = '0;
        end else begin
          for (int p = 3; p > 0; p--) mq[i][p] = mq[i][p-1];
          mq[i][0] = nw;
        end
        if (flushE && bc[i] < bmax[i]) bc[i] = bc[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic st_t act_m(input int i);
    return {o_v[i], o_rw[i], o_mr[i], o_mw[i], o_alu[i], o_wd[i], o_wr[i]};
  endfunction

  function automatic logic [15:0] act_cnt(input int i);
    return (i == 0) ? cnt1 : (i == 1) ? {14'b0, cnt2} : cnt3;
  endfunction

  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < 3; i++) begin
        logic        eh;
        logic [31:0] ed;
        eh = 1'b0;
        ed = '0;
        for (int p = 0; p < dep[i]; p++) begin
          if (!eh && mq[i][p].v && mq[i][p].rw && !mq[i][p].mr &&
              mq[i][p].wr == fwdqry && fwdqry != 5'd0) begin
            eh = 1'b1;
            ed = mq[i][p].alu;
          end
        end
        chk($sformatf("model_M_d%0d", dep[i]), 80'(act_m(i)), 80'(mq[i][dep[i]-1]));
        chk($sformatf("model_hit_d%0d", dep[i]), 80'(o_hit[i]), 80'(eh));
        chk($sformatf("model_fwd_d%0d", dep[i]), 80'(o_fd[i]), 80'(ed));
        chk($sformatf("model_cnt_d%0d", dep[i]), 80'(act_cnt(i)), 80'(bc[i]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, rw, mr, mw, input logic [31:0] alu, wd,
                     input logic [4:0] wr);
    validE = v; regwriteE = rw; memtoregE = mr; memwriteE = mw;
    aluoutE = alu; writedataE = wd; writeregE = wr;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_validM_d3", 80'(o_v[2]), 80'd0);
    chk("rst_alu_d3", 80'(o_alu[2]), 80'd0);
    chk("rst_cnt_d2", 80'(cnt2), 80'd0);
    run_chk = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single item through DEPTH=1
    drv(1, 1, 0, 0, 32'h0000_00A5, 32'h0, 5'd3);
    tick;
    chk("d1_regwriteM", 80'(o_rw[0]), 80'd1);
    chk("d1_aluoutM", 80'(o_alu[0]), 80'hA5);
    chk("d1_writeregM", 80'(o_wr[0]), 80'd3);
    chk("d1_validM", 80'(o_v[0]), 80'd1);

    // Stream 1..4 through DEPTH=3 with a two-cycle stall
    drv(1, 1, 0, 0, 32'd1, 32'h0, 5'd1); tick;
    drv(1, 1, 0, 0, 32'd2, 32'h0, 5'd2); tick;
    chk("d3_lat_not_early", 80'(o_alu[2]), 80'hA5);
    drv(1, 1, 0, 0, 32'd3, 32'h0, 5'd3); tick;
    chk("d3_lat_first", 80'(o_alu[2]), 80'd1);
    drv(1, 1, 0, 0, 32'd4, 32'h0, 5'd4); tick;
    chk("d3_seq2", 80'(o_alu[2]), 80'd2);
    stallE = 1'b1;
    tick; chk("d3_stall1", 80'(o_alu[2]), 80'd2);
    tick; chk("d3_stall2", 80'(o_alu[2]), 80'd2);
    stallE = 1'b0;
    drv(0, 0, 0, 0, 32'd0, 32'h0, 5'd0);
    tick; chk("d3_seq3", 80'(o_alu[2]), 80'd3);
    tick; chk("d3_seq4", 80'(o_alu[2]), 80'd4);
    tick; chk("d3_drain_valid", 80'(o_v[2]), 80'd0);

    // Flush and flush+stall on DEPTH=2
    do_reset;
    drv(1, 0, 0, 1, 32'h55, 32'h66, 5'd4);
    flushE = 1'b1; tick;
    flushE = 1'b0;
    drv(0, 0, 0, 0, 32'h0, 32'h0, 5'd0); tick;
    chk("d2_flush_memwriteM", 80'(o_mw[1]), 80'd0);
    chk("d2_flush_validM", 80'(o_v[1]), 80'd0);
    chk("d2_flush_cnt", 80'(cnt2), 80'd1);
    drv(1, 1, 0, 0, 32'h77, 32'h0, 5'd7); tick;
    drv(1, 1, 0, 0, 32'h88, 32'h0, 5'd8); tick;
    flushE = 1'b1; stallE = 1'b1; tick;
    chk("d2_fs_hold_alu", 80'(o_alu[1]), 80'h77);
    chk("d2_fs_hold_valid", 80'(o_v[1]), 80'd1);
    chk("d2_fs_cnt", 80'(cnt2), 80'd2);
    fwdqry = 5'd7; #1;
    chk("d2_fs_fwd_hit", 80'(o_hit[1]), 80'd1);
    chk("d2_fs_fwd_data", 80'(o_fd[1]), 80'h77);
    fwdqry = 5'd8; #1;
    chk("d2_fs_s1_cleared", 80'(o_hit[1]), 80'd0);
    flushE = 1'b0; stallE = 1'b0; fwdqry = 5'd0;

    // Forwarding priority on DEPTH=3
    do_reset;
    drv(1, 1, 0, 0, 32'h33, 32'h0, 5'd5); tick;
    drv(1, 1, 0, 0, 32'h22, 32'h0, 5'd9); tick;
    drv(1, 1, 0, 0, 32'h11, 32'h0, 5'd5); tick;
    fwdqry = 5'd5; #1;
    chk("d3_fwd_hit", 80'(o_hit[2]), 80'd1);
    chk("d3_fwd_youngest", 80'(o_fd[2]), 80'h11);
    fwdqry = 5'd0; #1;
    chk("d3_fwd_r0_hit", 80'(o_hit[2]), 80'd0);
    chk("d3_fwd_r0_data", 80'(o_fd[2]), 80'd0);
    fwdqry = 5'd9; #1;
    chk("d3_fwd_mid", 80'(o_fd[2]), 80'h22);
    drv(1, 1, 1, 0, 32'h44, 32'h0, 5'd5); tick;
    fwdqry = 5'd5; #1;
    chk("d3_fwd_skip_load", 80'(o_fd[2]), 80'h11);
    chk("d1_fwd_load_nohit", 80'(o_hit[0]), 80'd0);
    fwdqry = 5'd0;

    // Saturating counter, CNT_W=2
    do_reset;
    drv(1, 1, 0, 1, 32'h9, 32'h9, 5'd9);
    flushE = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick;
      chk($sformatf("d2_sat_%0d", k), 80'(cnt2), 80'((k + 1 > 3) ? 3 : k + 1));
    end
    flushE = 1'b0;

    // Asynchronous reset of a full pipeline mid flush+stall
    do_reset;
    drv(1, 1, 0, 1, 32'hA1, 32'hB1, 5'd10); tick;
    drv(1, 1, 0, 1, 32'hA2, 32'hB2, 5'd11); tick;
    drv(1, 1, 0, 1, 32'hA3, 32'hB3, 5'd12); tick;
    fwdqry = 5'd12; #1;
    chk("full_pre_hit", 80'(o_hit[2]), 80'd1);
    flushE = 1'b1; stallE = 1'b1;
    rst_n = 1'b0; #1;
    chk("arst_valid_d3", 80'(o_v[2]), 80'd0);
    chk("arst_alu_d3", 80'(o_alu[2]), 80'd0);
    chk("arst_mw_d3", 80'(o_mw[2]), 80'd0);
    chk("arst_hit_d3", 80'(o_hit[2]), 80'd0);
    chk("arst_alu_d1", 80'(o_alu[0]), 80'd0);
    chk("arst_cnt_d3", 80'(cnt3), 80'd0);
    #1;
    rst_n = 1'b1;
    flushE = 1'b0; stallE = 1'b0; fwdqry = 5'd0;
    drv(1, 1, 0, 0, 32'hBEEF, 32'h0, 5'd2); tick;
    chk("post_rst_capture_d1", 80'(o_alu[0]), 80'hBEEF);

    // Mixed directed pattern, checked by the model each cycle
    for (int i = 0; i < 60; i++) begin
      stallE = (i % 5 == 2);
      flushE = (i % 7 == 3) || (i % 11 == 0);
      drv(i % 3 != 0, i % 2 == 1, i % 4 == 1, i % 3 == 2,
          32'(i) * 32'h0101_0101 ^ 32'h5A, ~32'(i), 5'(i % 8));
      fwdqry = 5'((i + 3) % 8);
      tick;
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipereg_em_param.md
PIPEREG_EM_PARAM -- requirements
Module: pipereg_em_param

Interface
REQ-001 Parameter XLEN, default 32: width of aluout and writedata.
REQ-002 Parameter RADDR_W, default 5: width of the destination register index.
REQ-003 Parameter DEPTH, default 1, legal 1..4: number of cascaded Execute-to-Memory register stages.
REQ-004 Parameter CNT_W, default 16: width of the bubble counter.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 stallE  in  1  hold all stages.
REQ-008 flushE  in  1  insert a bubble into stage 1.
REQ-009 validE  in  1  the Execute-side instruction is real.
REQ-010 regwriteE, memtoregE, memwriteE  in  1 each  control bits from Execute.
REQ-011 aluoutE, writedataE  in  XLEN each  data from Execute.
REQ-012 writeregE  in  RADDR_W  destination register.
REQ-013 validM, regwriteM, memtoregM, memwriteM  out  1 each  stage-DEPTH control.
REQ-014 aluoutM, writedataM  out  XLEN each; writeregM  out  RADDR_W  stage-DEPTH data.
REQ-015 fwdqry  in  RADDR_W  register index to check for in-flight writes.
REQ-016 fwdhit  out  1; fwddata  out  XLEN  forwarding result.
REQ-017 bubblecnt  out  CNT_W  count of inserted bubbles.

Function
REQ-018 Stage k holds {valid, regwrite, memtoreg, memwrite, aluout, writedata, writereg}; stage 1 is fed from the E inputs, and stage k+1 is fed from stage k.
REQ-019 The M outputs are driven directly from stage DEPTH registers, with no combinational path from the E inputs.
REQ-020 Latency with no stall or flush is exactly DEPTH cycles.
REQ-021 With stallE=1 and flushE=0, every stage holds its value.
REQ-022 With flushE=1, stage 1 loads all-zero fields (valid=0, control=0, data=0, writereg=0) on the edge.
REQ-023 With flushE=1 and stallE=1 together, stage 1 is cleared, stages 2..DEPTH hold, and flush has priority over stall for stage 1.
REQ-024 A stage whose valid=0 has all its control bits 0, so no bubble can write memory or the register file.
REQ-025 The stage-1 loaded regwrite, memtoreg and memwrite each equal the corresponding E input ANDed with validE.
REQ-026 fwdhit=1 when any stage k has valid=1, regwrite=1, memtoreg=0, writereg==fwdqry and fwdqry!=0.
REQ-027 fwddata is the aluout of the lowest-numbered (youngest) matching stage, and 0 when fwdhit=0.
REQ-028 fwdhit and fwddata are combinational from the stage registers and fwdqry only.
REQ-029 bubblecnt increments by 1 on each edge where flushE=1, including when stallE=1.
REQ-030 bubblecnt saturates at 2^CNT_W-1 and does not wrap.
REQ-031 DEPTH outside 1..4 is a fatal elaboration error.

Reset
REQ-032 While rst_n=0, all stage fields and bubblecnt are 0 asynchronously, so all M outputs are 0 and fwdhit=0.
REQ-033 A rst_n assertion mid-stall or mid-flush clears the state immediately, and the first capture after rst_n rises occurs on the next rising edge.
REQ-034 Reset has priority over stallE and flushE.

Verification
REQ-035 DEPTH=1: rst_n released, validE=1, regwriteE=1, aluoutE=0x0000_00A5, writeregE=3 -> one edge later regwriteM=1, aluoutM=0xA5, writeregM=3, validM=1.
REQ-036 DEPTH=3: stream aluoutE=1,2,3,4 on consecutive cycles -> aluoutM=1 appears exactly 3 edges after the first; stallE=1 for 2 cycles freezes aluoutM for 2 cycles, and the sequence resumes in order with nothing lost or duplicated.
REQ-037 DEPTH=2: flushE=1 with memwriteE=1 -> after 2 edges memwriteM=0, validM=0 and bubblecnt=1; flushE=1 with stallE=1 clears stage 1 only, stage 2 holds and bubblecnt=2.
REQ-038 DEPTH=3: stage 1 writereg=5 aluout=0x11 and stage 3 writereg=5 aluout=0x33, both regwrite=1, with fwdqry=5 -> fwdhit=1 and fwddata=0x11; fwdqry=0 -> fwdhit=0; a matching stage with memtoreg=1 -> no hit from that stage.
REQ-039 CNT_W=2: hold flushE=1 for 6 edges -> bubblecnt reads 1,2,3,3,3,3.
REQ-040 Load a full pipeline, assert rst_n=0 between edges -> all outputs read 0 before the next edge.
